// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg
// Shared types and constants for the rx_frame_ctrl slice.
//   rx_frame_state_e : parser FSM states (also exported on the debug port)
//   rx_frame_err_e   : discard cause reported on err_code
//   RX_FRAME_HEADER  : start-of-frame byte
package rx_frame_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_LEN     = 3'd1,
    RX_PAYLOAD = 3'd2,
    RX_CSUM    = 3'd3,
    RX_DRAIN   = 3'd4
  } rx_frame_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } rx_frame_err_e;

  localparam logic [7:0] RX_FRAME_HEADER = 8'hAA;

endpackage

// File: rtl/rx_frame_buf.sv
// rx_frame_buf
// Payload buffer: MAX_LEN x 8 register array, one synchronous write port and
// one combinational read port so read data is usable in the address cycle.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module rx_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_LEN];

  // Storage only; contents are always written before they are read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
// Sequences rx_module and parses its byte stream into frames of the form
// AA, len, payload[len], csum (csum = len + sum(payload), mod 256).
// Payload is buffered and released only after the checksum matches.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_en_sig   out   enable to rx_module (low while draining)
//   rx_done_sig in    one-cycle byte strobe, rx_data valid with it
//   rx_data     in    received byte
//   out_data    out   payload byte buf[rd_ptr]
//   out_valid   out   payload byte available
//   out_ready   in    downstream accepts the byte
//   out_last    out   current byte is the last of the frame
//   frame_err   out   one-cycle pulse on discard
//   err_code    out   cause of last discard, held
//   frame_cnt   out   good frames fully drained, wrapping
//   number_data out   first payload byte of last good frame
//   dbg_state   out   current FSM state
// Handshake: a byte transfers on every cycle where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_data/out_last hold.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rx_en_sig,
  input  logic            rx_done_sig,
  input  logic [7:0]      rx_data,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [7:0]      frame_cnt,
  output logic [7:0]      number_data,
  output rx_frame_state_e dbg_state
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  rx_frame_state_e state_q, state_d;
  rx_frame_err_e   err_code_q, err_code_d;
  logic [PW-1:0]   len_q, len_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      first_q, first_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      number_data_q, number_data_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_en_q, rx_en_d;
  logic            buf_we;
  logic            counting;
  logic            tmo_hit;
  logic            last_xfer;

  rx_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (IW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q[IW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_q[IW-1:0]),
    .rdata (out_data)
  );

  assign out_valid = (state_q == RX_DRAIN);
  assign out_last  = out_valid && (rd_ptr_q == len_q - PW'(1));
  assign last_xfer = out_last && out_ready;

  // The inter-byte timer only runs while a frame is open. A byte in the
  // terminal-count cycle takes priority, so tmo_hit excludes rx_done_sig.
  assign counting = (state_q == RX_LEN) || (state_q == RX_PAYLOAD) ||
                    (state_q == RX_CSUM);
  assign tmo_hit  = counting && !rx_done_sig && (tmo_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    err_code_d    = err_code_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    csum_d        = csum_q;
    first_d       = first_q;
    frame_cnt_d   = frame_cnt_q;
    number_data_d = number_data_q;
    frame_err_d   = 1'b0;
    buf_we        = 1'b0;
    tmo_d         = (counting && !rx_done_sig && !tmo_hit) ? tmo_q + TW'(1) : '0;

    case (state_q)
      RX_IDLE: begin
        if (rx_done_sig && rx_data == RX_FRAME_HEADER) begin
          state_d = RX_LEN;
        end
      end
      RX_LEN: begin
        if (rx_done_sig) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            state_d  = RX_PAYLOAD;
            len_d    = rx_data[PW-1:0];
            csum_d   = rx_data;
            wr_ptr_d = '0;
          end
        end
      end
      RX_PAYLOAD: begin
        if (rx_done_sig) begin
          buf_we   = 1'b1;
          csum_d   = csum_q + rx_data;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q == '0) begin
            first_d = rx_data;
          end
          if (wr_ptr_q == len_q - PW'(1)) begin
            state_d = RX_CSUM;
          end
        end
      end
      RX_CSUM: begin
        if (rx_done_sig) begin
          if (rx_data == csum_q) begin
            state_d  = RX_DRAIN;
            rd_ptr_d = '0;
          end else begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
      end
      RX_DRAIN: begin
        // rx_module is disabled here; any stray byte strobe is ignored.
        if (last_xfer) begin
          state_d       = RX_IDLE;
          rd_ptr_d      = '0;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          number_data_d = first_q;
        end else if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    if (tmo_hit) begin
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end

    rx_en_d = (state_d != RX_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      err_code_q    <= ERR_NONE;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tmo_q         <= '0;
      csum_q        <= '0;
      first_q       <= '0;
      frame_cnt_q   <= '0;
      number_data_q <= '0;
      frame_err_q   <= 1'b0;
      rx_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_code_q    <= err_code_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tmo_q         <= tmo_d;
      csum_q        <= csum_d;
      first_q       <= first_d;
      frame_cnt_q   <= frame_cnt_d;
      number_data_q <= number_data_d;
      frame_err_q   <= frame_err_d;
      rx_en_q       <= rx_en_d;
    end
  end

  assign rx_en_sig   = rx_en_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;
  assign number_data = number_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
// Directed scenarios with literal expectations, then randomized frames.
// A frame-level reference model tracks open frame bytes and the pending
// payload queue; a negedge process compares every output against it.
module tb_rx_frame_ctrl;
  import rx_frame_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_done_sig = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic out_ready = 1'b1;
  logic rx_en_sig, out_valid, out_last, frame_err;
  logic [7:0] out_data, frame_cnt, number_data;
  logic [1:0] err_code;
  rx_frame_state_e dbg_state;

  always #5 clk = ~clk;

  rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en_sig   (rx_en_sig),
    .rx_done_sig (rx_done_sig),
    .rx_data     (rx_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .frame_cnt   (frame_cnt),
    .number_data (number_data),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_valid = 1'b0;
  bit         m_open;
  logic [7:0] m_body[$];   // length byte followed by payload/checksum bytes
  logic [7:0] m_drain[$];  // accepted payload not yet transferred
  logic [7:0] m_first;
  logic [7:0] m_sum;
  int         m_idle;
  logic       e_err;
  logic [1:0] e_code;
  logic [7:0] e_cnt, e_num;
  logic       e_en;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_open  = 1'b0;
      m_body.delete();
      m_drain.delete();
      m_idle  = 0;
      e_err   = 1'b0;
      e_code  = 2'd0;
      e_cnt   = 8'd0;
      e_num   = 8'd0;
      e_en    = 1'b0;
    end else begin
      e_err = 1'b0;
      if (m_drain.size() > 0) begin
        if (out_ready) begin
          void'(m_drain.pop_front());
          if (m_drain.size() == 0) begin
            e_cnt = e_cnt + 8'd1;
            e_num = m_first;
          end
        end
      end else if (!m_open) begin
        if (rx_done_sig && rx_data == 8'hAA) begin
          m_open = 1'b1;
          m_body.delete();
          m_idle = 0;
        end
      end else if (rx_done_sig) begin
        m_idle = 0;
        m_body.push_back(rx_data);
        if (m_body.size() == 1 && (rx_data == 8'd0 || int'(rx_data) > MAX_LEN)) begin
          m_open = 1'b0; e_err = 1'b1; e_code = 2'd1;
        end else if (m_body.size() > 1 && m_body.size() == int'(m_body[0]) + 2) begin
          m_sum = 8'd0;
          for (int i = 0; i < m_body.size() - 1; i++) m_sum = m_sum + m_body[i];
          m_open = 1'b0;
          if (m_sum == m_body[m_body.size()-1]) begin
            for (int i = 1; i < m_body.size() - 1; i++) m_drain.push_back(m_body[i]);
            m_first = m_body[1];
          end else begin
            e_err = 1'b1; e_code = 2'd2;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_open = 1'b0; e_err = 1'b1; e_code = 2'd3;
        end
      end
      e_en = (m_drain.size() == 0);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("rx_en", rx_en_sig, e_en);
      check("out_valid", out_valid, (m_drain.size() > 0));
      check("frame_err", frame_err, e_err);
      check("err_code", err_code, e_code);
      check("frame_cnt", frame_cnt, e_cnt);
      check("number_data", number_data, e_num);
      if (m_drain.size() > 0) begin
        check("out_data", out_data, m_drain[0]);
        check("out_last", out_last, (m_drain.size() == 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_ready = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one byte for one cycle, then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_done_sig = 1'b1;
    rx_data     = b;
    step();
    rx_done_sig = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (m_drain.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_bound", (n < 500), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] lost [3];
    logic [7:0] fr[$];
    int n, kind, len, k;
    logic [7:0] s, b;

    lost[0] = 8'hAA; lost[1] = 8'h01; lost[2] = 8'h44;

    rst = 1'b1;
    step(); step();
    check("rst_state", dbg_state, RX_IDLE);
    check("rst_rx_en", rx_en_sig, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_number_data", number_data, 0);
    rst = 1'b0;
    step();
    check("rx_en_rise", rx_en_sig, 1);

    // good frame
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h69, 0);
    check("good_valid", out_valid, 1);
    check("good_en_low", rx_en_sig, 0);
    check("good_d0", out_data, 8'h11); check("good_l0", out_last, 0);
    step();
    check("good_d1", out_data, 8'h22); check("good_l1", out_last, 0);
    step();
    check("good_d2", out_data, 8'h33); check("good_l2", out_last, 1);
    step();
    check("good_done_valid", out_valid, 0);
    check("good_done_en", rx_en_sig, 1);
    check("good_cnt", frame_cnt, 1);
    check("good_num", number_data, 8'h11);

    // checksum mismatch
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h68, 0);
    check("csum_err", frame_err, 1); check("csum_code", err_code, 2);
    step();
    check("csum_pulse", frame_err, 0); check("csum_cnt", frame_cnt, 1);

    // bad lengths, then a good one-byte frame
    send_byte(8'hAA, 0); send_byte(8'h00, 0);
    check("len0_err", frame_err, 1); check("len0_code", err_code, 1);
    send_byte(8'hAA, 0); send_byte(8'h11, 0);
    check("len17_err", frame_err, 1); check("len17_code", err_code, 1);
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h5A, 0); send_byte(8'h5B, 0);
    check("len_ok_d", out_data, 8'h5A); check("len_ok_l", out_last, 1);
    step();
    check("len_ok_cnt", frame_cnt, 2); check("len_ok_num", number_data, 8'h5A);

    // timeout latency
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    n = 0;
    while (frame_err !== 1'b1 && n < 3 * TMO) begin
      step();
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_code", err_code, 3);

    // byte on the terminal-count cycle wins
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    repeat (TMO - 1) step();
    send_byte(8'h22, 0);
    check("tc_no_err", frame_err, 0); check("tc_code_held", err_code, 3);
    send_byte(8'h35, 0);
    check("tc_d0", out_data, 8'h11);
    step();
    check("tc_d1", out_data, 8'h22); check("tc_l1", out_last, 1);
    step();
    check("tc_cnt", frame_cnt, 3);

    // backpressure, with bytes sent during drain
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'hA5, 0); send_byte(8'h5A, 0);
    out_ready = 1'b0;
    send_byte(8'h01, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data, 8'hA5);
      check("bp_valid", out_valid, 1);
      check("bp_en", rx_en_sig, 0);
      if (i < 3) send_byte(lost[i], 0);
      else step();
    end
    out_ready = 1'b1;
    step();
    check("bp_d1", out_data, 8'h5A); check("bp_l1", out_last, 1);
    step();
    check("bp_cnt", frame_cnt, 4);
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h44, 0); send_byte(8'h45, 0);
    check("bp_next_d", out_data, 8'h44);
    step();
    check("bp_next_cnt", frame_cnt, 5);

    // reset mid-frame
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    rst = 1'b1;
    step();
    check("mid_rst_state", dbg_state, RX_IDLE);
    check("mid_rst_en", rx_en_sig, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_err", frame_err, 0);
    check("mid_rst_code", err_code, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_num", number_data, 0);
    rst = 1'b0;
    step();
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    check("post_rst_d", out_data, 8'h07); check("post_rst_l", out_last, 1);
    step();
    check("post_rst_cnt", frame_cnt, 1); check("post_rst_num", number_data, 8'h07);

    // randomized frames
    rand_ready = 1'b1;
    for (int f = 0; f < 250; f++) begin
      wait_drain();
      kind = $urandom_range(0, 7);
      fr.delete();
      if (kind == 7) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hAA) b = 8'h55;
          fr.push_back(b);
        end
      end
      len = $urandom_range(1, MAX_LEN);
      fr.push_back(8'hAA);
      if (kind == 5) begin
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        fr.push_back(8'(len));
        s = 8'(len);
        k = (kind == 6) ? $urandom_range(0, len) : len;
        for (int i = 0; i < k; i++) begin
          b = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom_range(0, 255));
          fr.push_back(b);
          s = s + b;
        end
        if (kind == 4) fr.push_back(s ^ 8'($urandom_range(1, 255)));
        else if (kind != 6) fr.push_back(s);
      end
      foreach (fr[i]) send_byte(fr[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      if (kind == 6) repeat ($urandom_range(TMO - 2, TMO + 2)) step();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    repeat (TMO + 5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
